// File: rtl/seq_frame_pkg.sv
// Shared definitions for the serial sync-word link: state encoding,
// default frame geometry and counter sizing.
package seq_frame_pkg;

    // Frame FSM state encoding; codes 1xx are unused and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_SYNC = 3'b001,
        ST_DATA = 3'b010,
        ST_GAP  = 3'b011
    } state_t;

    localparam int                      SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0]   SYNC_DEF   = 4'b1011;
    localparam int                      DATA_W_DEF = 8;
    localparam int                      GAP_DEF    = 2;

    // Bit counter width: enough to hold the largest phase length minus one.
    function automatic int cnt_width(input int sync_w, input int data_w, input int gap);
        int m;
        m = 2;
        if (sync_w > m) m = sync_w;
        if (data_w > m) m = data_w;
        if (gap > m)    m = gap;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seq_frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register holding the payload being sent.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb
);

    logic [DATA_W-1:0] r_shift;

    // Load has priority over shift; register cleared on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= r_shift << 1;
        end
    end

    assign o_msb = r_shift[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word, payload (MSB first), then idle gap
// zeros, one bit per clock on a registered dout.
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int                SYNC_W = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                GAP    = GAP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        state
);

    localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_dout;
    logic             w_dout_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;
    logic             w_sync_bit;

    piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (tx_data),
        .o_msb   (w_msb)
    );

    // Sync bit emitted next while in SYNC: SYNC[cnt-1] for cnt in 1..SYNC_W-1.
    always_comb begin
        w_sync_bit = 1'b0;
        for (int i = 1; i < SYNC_W; i++) begin
            if (r_cnt == CNT_W'(i)) w_sync_bit = SYNC[i-1];
        end
    end

    // Next-state, counter and registered-output decode for the frame FSM.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dout_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_load     = 1'b1;
                    w_dout_nx  = SYNC[SYNC_W-1];
                    w_cnt_nx   = CNT_W'(SYNC_W-1);
                    w_state_nx = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (r_cnt != '0) begin
                    w_dout_nx = w_sync_bit;
                    w_cnt_nx  = r_cnt - CNT_W'(1);
                end else begin
                    w_dout_nx  = w_msb;
                    w_shift    = 1'b1;
                    w_cnt_nx   = CNT_W'(DATA_W-1);
                    w_state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt != '0) begin
                    w_dout_nx = w_msb;
                    w_shift   = 1'b1;
                    w_cnt_nx  = r_cnt - CNT_W'(1);
                end else begin
                    w_done_nx = 1'b1;
                    if (GAP > 0) begin
                        w_cnt_nx   = CNT_W'(GAP-1);
                        w_state_nx = ST_GAP;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Bit counter and registered serial/pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nx;
            r_dout <= w_dout_nx;
            r_done <= w_done_nx;
        end
    end

    assign dout       = r_dout;
    assign frame_done = r_done;
    assign tx_ready   = (r_state == ST_IDLE);
    assign busy       = ~tx_ready;
    assign state      = r_state;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: per-cycle comparison of the observable outputs
// against a frame-position model, for the default geometry and for GAP=0.
module tb_seq_frame_tx;

    localparam int SW = 4;
    localparam int DW = 8;
    localparam int G  = 2;
    localparam int FL = SW + DW + G;
    localparam logic [SW-1:0] SYNC_WORD = 4'b1011;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] tx_data, tx_data0;
    logic          tx_valid, tx_valid0;
    logic          tx_ready, dout, busy, frame_done;
    logic [2:0]    state;
    logic          tx_ready0, dout0, busy0, frame_done0;
    logic [2:0]    state0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_frame_tx dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dout(dout), .busy(busy),
        .frame_done(frame_done), .state(state)
    );

    seq_frame_tx #(.GAP(0)) dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .dout(dout0), .busy(busy0),
        .frame_done(frame_done0), .state(state0)
    );

    // Expected {dout, frame_done, busy, tx_ready, state} in cycle k after the
    // accept edge of a frame carrying payload d (k >= frame length means idle).
    function automatic logic [6:0] exp_out(input logic [DW-1:0] d, input int k, input int g);
        logic [SW+DW-1:0] bits;
        logic             b, done, bsy, rdy;
        logic [2:0]       st;
        bits = {SYNC_WORD, d};
        b    = (k < SW + DW) ? bits[SW+DW-1-k] : 1'b0;
        if (k < SW)              st = 3'd1;
        else if (k < SW + DW)    st = 3'd2;
        else if (k < SW + DW + g) st = 3'd3;
        else                     st = 3'd0;
        done = (k == SW + DW);
        bsy  = (st != 3'd0);
        rdy  = (st == 3'd0);
        return {b, done, bsy, rdy, st};
    endfunction

    task automatic test_reset();
        logic [6:0] got;
        reset = 1'b0; tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (2) @(negedge clk);
        got = {dout, frame_done, busy, tx_ready, state};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL reset_hold got=%b exp=%b", got, 7'b0001000);
        end
        got = {dout0, frame_done0, busy0, tx_ready0, state0};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL reset_hold_gap0 got=%b exp=%b", got, 7'b0001000);
        end
        tx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        got = {dout, frame_done, busy, tx_ready, state};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", got, 7'b0001000);
        end
    endtask

    // Fixed payloads A5 and B0, plus sync-word hit count on the serial stream.
    task automatic test_fixed_payloads();
        logic [DW-1:0] pay [2];
        int            exp_hits [2];
        logic [6:0]    got, exp;
        logic [SW-1:0] win;
        int            hits;
        pay[0] = 8'hA5; exp_hits[0] = 1;
        pay[1] = 8'hB0; exp_hits[1] = 2;
        for (int p = 0; p < 2; p++) begin
            tx_data = pay[p]; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0; tx_data = 8'h00;
            win = '0; hits = 0;
            for (int k = 0; k <= FL; k++) begin
                got = {dout, frame_done, busy, tx_ready, state};
                exp = exp_out(pay[p], k, G);
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL fixed_%h k=%0d got=%b exp=%b", pay[p], k, got, exp);
                end
                win = {win[SW-2:0], dout};
                if (win == SYNC_WORD) hits++;
                @(negedge clk);
            end
            checks++;
            if (hits != exp_hits[p]) begin
                errors++; $display("FAIL sync_hits_%h got=%0d exp=%0d", pay[p], hits, exp_hits[p]);
            end
        end
    endtask

    // Random payloads with tx_valid/tx_data scrambled while the frame is in flight.
    task automatic test_random_frames();
        logic [DW-1:0] d;
        logic [6:0]    got, exp;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = DW'($urandom); tx_data = d; tx_valid = 1'b1;
            @(negedge clk);
            for (int k = 0; k <= FL; k++) begin
                got = {dout, frame_done, busy, tx_ready, state};
                exp = exp_out(d, k, G);
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL random_f%0d k=%0d got=%b exp=%b", f, k, got, exp);
                end
                if (k < FL) begin
                    tx_valid = 1'($urandom);
                    tx_data  = DW'($urandom);
                    @(negedge clk);
                end
            end
            tx_valid = 1'b0;
        end
    endtask

    // tx_valid held high: one IDLE cycle between frames, tx_ready high once per frame.
    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [6:0]    got, exp;
        int            rdy_cnt;
        d = DW'($urandom); tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            rdy_cnt = 0;
            for (int k = 0; k <= FL; k++) begin
                got = {dout, frame_done, busy, tx_ready, state};
                exp = exp_out(d, k, G);
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL b2b_f%0d k=%0d got=%b exp=%b", f, k, got, exp);
                end
                if (tx_ready) rdy_cnt++;
                if (k < FL) tx_data = DW'($urandom);
                @(negedge clk);
            end
            checks++;
            if (rdy_cnt != 1) begin
                errors++; $display("FAIL b2b_ready_f%0d got=%0d exp=1", f, rdy_cnt);
            end
            d = tx_data;
            if (f == 3) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        repeat (FL + 2) @(negedge clk);
    endtask

    // Reset after three payload bits, then a clean frame.
    task automatic test_reset_mid_data();
        logic [DW-1:0] d;
        logic [6:0]    got, exp;
        d = DW'($urandom); tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < SW + 3; k++) begin
            got = {dout, frame_done, busy, tx_ready, state};
            exp = exp_out(d, k, G);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL pre_abort k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        got = {dout, frame_done, busy, tx_ready, state};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL abort_immediate got=%b exp=%b", got, 7'b0001000);
        end
        repeat (2) @(negedge clk);
        got = {dout, frame_done, busy, tx_ready, state};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL abort_held got=%b exp=%b", got, 7'b0001000);
        end
        reset = 1'b1;
        d = DW'($urandom); tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k <= FL; k++) begin
            got = {dout, frame_done, busy, tx_ready, state};
            exp = exp_out(d, k, G);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL post_abort k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    // GAP=0 instance, zero payload, tx_valid held: 13-cycle period, one sync hit per frame.
    task automatic test_loopback_gap0();
        logic [6:0]    got, exp;
        logic [SW-1:0] win;
        int            hits, last_done, period;
        tx_data0 = 8'h00; tx_valid0 = 1'b1;
        @(negedge clk);
        win = '0; last_done = -1;
        for (int f = 0; f < 3; f++) begin
            hits = 0;
            for (int k = 0; k < SW + DW + 1; k++) begin
                got = {dout0, frame_done0, busy0, tx_ready0, state0};
                exp = exp_out(8'h00, k, 0);
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL gap0_f%0d k=%0d got=%b exp=%b", f, k, got, exp);
                end
                win = {win[SW-2:0], dout0};
                if (win == SYNC_WORD) hits++;
                if (frame_done0) begin
                    if (last_done >= 0) begin
                        period = cyc - last_done;
                        checks++;
                        if (period != 13) begin
                            errors++; $display("FAIL gap0_period got=%0d exp=13", period);
                        end
                    end
                    last_done = cyc;
                end
                if (f == 2 && k == SW + DW) tx_valid0 = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (hits != 1) begin
                errors++; $display("FAIL gap0_hits_f%0d got=%0d exp=1", f, hits);
            end
        end
        got = {dout0, frame_done0, busy0, tx_ready0, state0};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL gap0_idle got=%b exp=%b", got, 7'b0001000);
        end
    endtask

    initial begin
        reset = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tx_valid0 = 1'b0; tx_data0 = '0;
        test_reset();
        test_fixed_payloads();
        test_random_frames();
        test_back_to_back();
        test_reset_mid_data();
        test_loopback_gap0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
